// File: rtl/aesl_deadlock_report_collector.sv
// Confirms a persistent dataflow deadlock and streams a framed report of the blocked channels.
// Optional macro DEADLOCK_RPT_AUTO_REARM_EN: DONE lasts one cycle, then the collector re-arms itself.
module aesl_deadlock_report_collector #(
  parameter int NUM_CHAN       = 3,
  parameter int CODE_W         = 3,
  parameter int CONFIRM_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       block_in,
  input  logic [NUM_CHAN*CODE_W-1:0] axis_block_info_in,
  input  logic                       clear,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [31:0]                rpt_data,
  output logic                       rpt_last,
  output logic                       deadlock_confirmed
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMING, S_REPORT, S_DONE} state_e;
  typedef enum logic [1:0] {W_HDR, W_TS, W_CHAN} word_e;

  state_e                     state_q, state_d;
  word_e                      word_q, word_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [31:0]                ts_q, ts_d;
  logic [31:0]                onset_q, onset_d;
  logic [NUM_CHAN*CODE_W-1:0] snap_q, snap_d;
  logic [NUM_CHAN-1:0]        pend_q, pend_d;

  logic [NUM_CHAN-1:0]        info_nz;
  logic [IDX_W-1:0]           low_idx;
  logic [CODE_W-1:0]          low_code;
  logic [NUM_CHAN-1:0]        pend_rest;
  logic [15:0]                nz_cnt;

  // Lowest pending channel and the snapshot's nonzero-code count, shared by both comb paths.
  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    info_nz  = '0;
    low_idx  = '0;
    low_code = '0;
    nz_cnt   = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      info_nz[i] = |axis_block_info_in[i*CODE_W +: CODE_W];
      if (|snap_q[i*CODE_W +: CODE_W]) nz_cnt = nz_cnt + 16'd1;
    end
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_idx  = IDX_W'(i);
        low_code = snap_q[i*CODE_W +: CODE_W];
      end
    end
    pend_rest = pend_q & ~(NUM_CHAN'(1) << low_idx);
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    onset_d = onset_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    ts_d    = (ts_q == 32'hFFFF_FFFF) ? ts_q : ts_q + 32'd1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!clear && block_in) begin
          state_d = S_ARMING;
          cnt_d   = CNT_W'(1);
          onset_d = ts_q;
        end
      end
      S_ARMING: begin
        if (clear || !block_in) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_REPORT;
          word_d  = W_HDR;
          cnt_d   = '0;
          snap_d  = axis_block_info_in;
          pend_d  = info_nz;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // clear is deliberately ignored here so a started frame always completes.
      S_REPORT: begin
        if (rpt_ready) begin
          unique case (word_q)
            W_HDR: word_d = W_TS;
            W_TS: begin
              if (pend_q == '0) state_d = S_DONE;
              else              word_d  = W_CHAN;
            end
            default: begin
              pend_d = pend_rest;
              if (pend_rest == '0) state_d = S_DONE;
            end
          endcase
        end
      end
      default: begin
        cnt_d = '0;
`ifdef DEADLOCK_RPT_AUTO_REARM_EN
        state_d = S_IDLE;
`else
        if (clear) state_d = S_IDLE;
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= W_HDR;
      cnt_q   <= '0;
      ts_q    <= '0;
      onset_q <= '0;
      snap_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      onset_q <= onset_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs decode registered state only, so they hold steady while the sink stalls.
  always_comb begin
    rpt_valid          = (state_q == S_REPORT);
    deadlock_confirmed = (state_q == S_REPORT) || (state_q == S_DONE);
    rpt_data           = '0;
    rpt_last           = 1'b0;
    if (state_q == S_REPORT) begin
      unique case (word_q)
        W_HDR: rpt_data = {8'hDE, 8'(NUM_CHAN), nz_cnt};
        W_TS: begin
          rpt_data = onset_q;
          rpt_last = (pend_q == '0);
        end
        default: begin
          rpt_data = {16'(low_idx), 16'(low_code)};
          rpt_last = (pend_rest == '0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aesl_deadlock_report_collector.sv
// Scoreboard bench for aesl_deadlock_report_collector: stimulus queues expected report words,
// a negedge monitor pops and compares every accepted word and checks stall stability.
module tb_aesl_deadlock_report_collector;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        block_in = 1'b0;
  logic [8:0]  axis_block_info_in = '0;
  logic        clear = 1'b0;
  logic        rpt_valid;
  logic        rpt_ready = 1'b0;
  logic [31:0] rpt_data;
  logic        rpt_last;
  logic        deadlock_confirmed;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  word_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] tb_ts;
  logic [31:0] onset_exp;

  aesl_deadlock_report_collector #(
    .NUM_CHAN(3), .CODE_W(3), .CONFIRM_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .block_in(block_in),
    .axis_block_info_in(axis_block_info_in),
    .clear(clear),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_data(rpt_data),
    .rpt_last(rpt_last),
    .deadlock_confirmed(deadlock_confirmed)
  );

  always #5 clock = ~clock;

  // Reference cycle count: value the timestamp holds during the current cycle.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 32'd1;
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic last, input logic [31:0] data);
    word_t w;
    w.last = last;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Hold block_in high for n sampling edges.
  task automatic block_for(input int n);
    block_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      if (toggle) rpt_ready = ~rpt_ready;
      step();
    end
    check("drain_complete", 33'(exp_q.size()), 33'd0);
  endtask

  // Monitor: compare every accepted word, and require held data while stalled.
  word_t stall_w;
  bit    stall_prev = 1'b0;
  always @(negedge clock) begin
    word_t e;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && rpt_valid)
        check("stall_stable", {rpt_last, rpt_data}, {stall_w.last, stall_w.data});
      stall_prev = rpt_valid && !rpt_ready;
      stall_w    = '{last: rpt_last, data: rpt_data};
      if (rpt_valid && rpt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {rpt_last, rpt_data}, 33'd0);
        end else begin
          e = exp_q.pop_front();
          check("report_word", {rpt_last, rpt_data}, {e.last, e.data});
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    check("reset_valid", 33'(rpt_valid), 33'd0);
    check("reset_data", {rpt_last, rpt_data}, 33'd0);
    check("reset_confirmed", 33'(deadlock_confirmed), 33'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // 1: fifteen block cycles never confirm
    block_for(15);
    check("t1_valid", 33'(rpt_valid), 33'd0);
    block_in = 1'b0;
    step();
    check("t1_confirmed", 33'(deadlock_confirmed), 33'd0);
    check("t1_valid_after", 33'(rpt_valid), 33'd0);

    // 2: block rises at ts=100, full report, snapshot immune to later info changes
    while (tb_ts < 32'd100) step();
    check("t2_ts", tb_ts, 33'd100);
    rpt_ready = 1'b1;
    axis_block_info_in = 9'b110_000_101;
    push(1'b0, 32'hDE03_0002);
    push(1'b0, 32'h0000_0064);
    push(1'b0, 32'h0000_0005);
    push(1'b1, 32'h0002_0006);
    block_for(15);
    check("t2_not_yet", 33'(rpt_valid), 33'd0);
    step();
    check("t2_valid", 33'(rpt_valid), 33'd1);
    check("t2_confirmed", 33'(deadlock_confirmed), 33'd1);
    block_in = 1'b0;
    axis_block_info_in = 9'b111_111_111;
    drain(1'b0);
    check("t2_done_valid", 33'(rpt_valid), 33'd0);
`ifndef DEADLOCK_RPT_AUTO_REARM_EN
    check("t2_done_confirmed", 33'(deadlock_confirmed), 33'd1);
`endif
    pulse_clear();
    check("t2_cleared", 33'(deadlock_confirmed), 33'd0);

    // 3: same codes, sink toggling ready every cycle
    axis_block_info_in = 9'b110_000_101;
    rpt_ready = 1'b0;
    block_in = 1'b1;
    onset_exp = tb_ts;
    push(1'b0, 32'hDE03_0002);
    push(1'b0, onset_exp);
    push(1'b0, 32'h0000_0005);
    push(1'b1, 32'h0002_0006);
    block_for(16);
    check("t3_valid", 33'(rpt_valid), 33'd1);
    block_in = 1'b0;
    pulse_clear();
    check("t3_clear_ignored", 33'(rpt_valid), 33'd1);
    drain(1'b1);
    check("t3_done_valid", 33'(rpt_valid), 33'd0);
    pulse_clear();

    // 4: no nonzero codes, timestamp word is last
    rpt_ready = 1'b1;
    axis_block_info_in = '0;
    block_in = 1'b1;
    onset_exp = tb_ts;
    push(1'b0, 32'hDE03_0000);
    push(1'b1, onset_exp);
    block_for(16);
    block_in = 1'b0;
    drain(1'b0);
    check("t4_done_valid", 33'(rpt_valid), 33'd0);
    pulse_clear();

    // 5: reset after w1 accepted abandons the frame; fresh report afterwards
    axis_block_info_in = 9'b110_000_101;
    block_in = 1'b1;
    onset_exp = tb_ts;
    push(1'b0, 32'hDE03_0002);
    push(1'b0, onset_exp);
    block_for(16);
    block_in = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("t5_reset_valid", 33'(rpt_valid), 33'd0);
    check("t5_reset_data", {rpt_last, rpt_data}, 33'd0);
    check("t5_reset_confirmed", 33'(deadlock_confirmed), 33'd0);
    check("t5_frame_abandoned", 33'(exp_q.size()), 33'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    axis_block_info_in = 9'b000_111_000;
    block_in = 1'b1;
    onset_exp = tb_ts;
    push(1'b0, 32'hDE03_0001);
    push(1'b0, onset_exp);
    push(1'b1, 32'h0001_0007);
    block_for(16);
    drain(1'b0);

    // 6: block still high across DONE; re-arm via clear (or automatically)
`ifndef DEADLOCK_RPT_AUTO_REARM_EN
    repeat (20) step();
    check("t6_block_ignored", 33'(rpt_valid), 33'd0);
    check("t6_done_holds", 33'(deadlock_confirmed), 33'd1);
    pulse_clear();
    check("t6_cleared", 33'(deadlock_confirmed), 33'd0);
`else
    step();
    check("t6_auto_rearm", 33'(deadlock_confirmed), 33'd0);
`endif
    onset_exp = tb_ts;
    push(1'b0, 32'hDE03_0001);
    push(1'b0, onset_exp);
    push(1'b1, 32'h0001_0007);
    repeat (15) step();
    check("t6_not_yet", 33'(rpt_valid), 33'd0);
    step();
    check("t6_valid", 33'(rpt_valid), 33'd1);
    block_in = 1'b0;
    drain(1'b0);
    check("t6_done_valid", 33'(rpt_valid), 33'd0);

    repeat (3) step();
    check("final_queue_empty", 33'(exp_q.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
